// File: rtl/imem_arbiter_if.sv
// imem_arbiter_if
//   One requester port of the instruction-ROM arbiter: request channel
//   (valid/ready/address) and response channel (valid/ready/data).
//   modport master : the requester (CPU fetch path or debug/loader path)
//   modport slave  : the arbiter side
//   Signals:
//     req_valid  requester -> arbiter  read request
//     req_ready  arbiter -> requester  request granted this cycle
//     req_addr   requester -> arbiter  ROM word address
//     rsp_valid  arbiter -> requester  response available
//     rsp_ready  requester -> arbiter  response consumed
//     rsp_data   arbiter -> requester  read data (FIFO head)
interface imem_arbiter_if #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_data;

  modport master (
    output req_valid, req_addr, rsp_ready,
    input  req_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  req_valid, req_addr, rsp_ready,
    output req_ready, rsp_valid, rsp_data
  );
endinterface

// File: rtl/imem_arbiter.sv
// imem_arbiter
//   Shares a single-read-port, 1-cycle-latency instruction ROM between
//   port 0 (CPU fetch) and port 1 (debug/loader). One ROM read is issued
//   per cycle; each port gets its read data back in order through its own
//   2-entry response FIFO with valid/ready backpressure.
//   Ports:
//     clka       clock shared with the ROM
//     rsta       synchronous active-high reset
//     p0, p1     requester ports (imem_arbiter_if.slave)
//     rom_addra  ROM address (granted port's address, 0 when idle)
//     rom_rsta   ROM output reset, tied to rsta
//     rom_doa    ROM read data, valid the cycle after the address edge
//   Build option:
//     IMEM_ARB_FIXED_PRIO_EN  defined: port 0 always wins contention.
//                             undefined: round-robin between the ports.
module imem_arbiter #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 32
) (
  input  logic              clka,
  input  logic              rsta,
  imem_arbiter_if.slave     p0,
  imem_arbiter_if.slave     p1,
  output logic [ADDR_W-1:0] rom_addra,
  output logic              rom_rsta,
  input  logic [DATA_W-1:0] rom_doa
);

  logic [1:0]              w_req_valid;
  logic [1:0]              w_rsp_ready;
  logic [1:0]              w_push;
  logic [1:0]              w_pop;
  logic [1:0]              w_elig;
  logic [1:0]              w_cand;
  logic [1:0]              w_ready;
  logic [1:0]              w_grant;
  logic [1:0]              w_not_empty;
  logic [1:0][1:0]         w_cnt;
  logic [1:0][DATA_W-1:0]  w_rsp_data;
  logic                    w_favor0;

  // Outstanding-read tag: which port the ROM data of this cycle belongs to.
  logic                    r_tag_vld;
  logic                    r_tag_port;

  assign w_req_valid = {p1.req_valid, p0.req_valid};
  assign w_rsp_ready = {p1.rsp_ready, p0.rsp_ready};

  // Per-port response FIFO and eligibility.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_port
      logic [DATA_W-1:0] r_mem [2];
      logic              r_wr_ptr;
      logic              r_rd_ptr;
      logic [1:0]        r_cnt;
      logic [1:0]        w_credit;

      assign w_push[gi]      = r_tag_vld && (r_tag_port == 1'(gi));
      assign w_not_empty[gi] = (r_cnt != 2'd0);
      assign w_pop[gi]       = w_not_empty[gi] && w_rsp_ready[gi];
      // Credit counts the in-flight read plus buffered entries, so a port
      // can never have more reads outstanding than its FIFO can hold.
      assign w_credit        = r_cnt + 2'(w_push[gi]);
      // At full credit a pop this cycle frees a slot just in time.
      assign w_elig[gi]      = (w_credit < 2'd2) || ((w_credit == 2'd2) && w_pop[gi]);
      assign w_cnt[gi]       = r_cnt;
      assign w_rsp_data[gi]  = r_mem[r_rd_ptr];

      always_ff @(posedge clka) begin
        if (rsta) begin
          r_wr_ptr <= 1'b0;
          r_rd_ptr <= 1'b0;
          r_cnt    <= 2'd0;
        end else begin
          if (w_push[gi]) r_wr_ptr <= ~r_wr_ptr;
          if (w_pop[gi])  r_rd_ptr <= ~r_rd_ptr;
          r_cnt <= r_cnt + 2'(w_push[gi]) - 2'(w_pop[gi]);
        end
      end

      // Storage has no reset; occupancy alone decides what is valid.
      always_ff @(posedge clka) begin
        if (w_push[gi]) r_mem[r_wr_ptr] <= rom_doa;
      end
    end
  endgenerate

  assign p0.rsp_valid = w_not_empty[0];
  assign p1.rsp_valid = w_not_empty[1];
  assign p0.rsp_data  = w_rsp_data[0];
  assign p1.rsp_data  = w_rsp_data[1];

`ifdef IMEM_ARB_FIXED_PRIO_EN
  assign w_favor0 = 1'b1;
`else
  // Last granted port; 1 out of reset so port 0 wins the first contention.
  logic r_last;

  always_ff @(posedge clka) begin
    if (rsta) begin
      r_last <= 1'b1;
    end else if (w_grant != 2'b00) begin
      r_last <= w_grant[1];
    end
  end

  assign w_favor0 = r_last;
`endif

  // A port is offered ready only if it is eligible and does not lose to a
  // contending port. Ready depends on the other port's valid, never its own.
  always_comb begin
    w_cand     = rsta ? 2'b00 : w_elig;
    w_ready    = 2'b00;
    w_ready[0] = w_cand[0] && (!(w_cand[1] && w_req_valid[1]) || w_favor0);
    w_ready[1] = w_cand[1] && (!(w_cand[0] && w_req_valid[0]) || !w_favor0);
    w_grant    = w_ready & w_req_valid;
  end

  assign p0.req_ready = w_ready[0];
  assign p1.req_ready = w_ready[1];

  always_comb begin
    rom_addra = '0;
    if (w_grant[0])      rom_addra = p0.req_addr;
    else if (w_grant[1]) rom_addra = p1.req_addr;
  end

  assign rom_rsta = rsta;

  always_ff @(posedge clka) begin
    if (rsta) begin
      r_tag_vld  <= 1'b0;
      r_tag_port <= 1'b0;
    end else begin
      r_tag_vld  <= w_grant[0] || w_grant[1];
      r_tag_port <= w_grant[1];
    end
  end

endmodule
